// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// Module   : seg7_pkg
// Purpose  : Shared 7-segment glyph patterns, decode codes and scan FSM states
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// Module   : seg7_pattern_decode
// Purpose  : Combinational segment-pattern to 4-bit code decoder
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    code_o  = CODE_ERR;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_BLANK: begin
        code_o  = CODE_BLANK;
        blank_o = 1'b1;
      end
      default:   err_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// Module   : seg7_scan_decoder
// Purpose  : Glitch-filtered multiplexed 7-segment bus decoder, frame output
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_sel_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic [NUM_DIGITS-1:0]   err_o,
  output logic                    frame_valid_o,
  output logic                    timeout_o
);

  localparam int              PW       = NUM_DIGITS + 7;
  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMO_PRE  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      STABLE_N = 8'(STABLE_CYCLES);

  scan_state_e               state_q, state_d;
  logic [7:0]                hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]             p_prev_q;
  logic [TW-1:0]             tmo_cnt_q, tmo_cnt_d;
  logic                      timeout_q, timeout_d;
  logic [NUM_DIGITS-1:0]     seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0]   shadow_code_q, shadow_code_d;
  logic [NUM_DIGITS-1:0]     shadow_blank_q, shadow_blank_d;
  logic [NUM_DIGITS-1:0]     shadow_err_q, shadow_err_d;
  logic [4*NUM_DIGITS-1:0]   digits_q;
  logic [NUM_DIGITS-1:0]     blank_q, err_q;
  logic                      frame_valid_q;

  logic [PW-1:0]             w_p;
  logic                      w_onehot, w_changed, w_accept, w_publish, w_fire;
  logic [NUM_DIGITS-1:0]     w_accept_mask, w_seen_next;
  logic [3:0]                w_code;
  logic                      w_blank, w_err;

  seg7_pattern_decode u_decode (
    .seg_i   (seg_i),
    .code_o  (w_code),
    .blank_o (w_blank),
    .err_o   (w_err)
  );

  assign w_p       = {dig_sel_i, seg_i};
  assign w_onehot  = $onehot(dig_sel_i);
  assign w_changed = (w_p != p_prev_q);

  // Entering a new pattern counts as its first stable cycle.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    w_accept   = 1'b0;
    if (!w_onehot) begin
      state_d    = WAIT;
      hold_cnt_d = 8'd0;
    end else if (state_q == WAIT || w_changed) begin
      hold_cnt_d = 8'd1;
      if (STABLE_N == 8'd1) begin
        w_accept = 1'b1;
        state_d  = DONE;
      end else begin
        state_d  = HOLD;
      end
    end else if (state_q == HOLD) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
      if (hold_cnt_d >= STABLE_N) begin
        w_accept = 1'b1;
        state_d  = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT;
      hold_cnt_q <= 8'd0;
      p_prev_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      p_prev_q   <= w_p;
    end
  end

  assign w_accept_mask = w_accept ? dig_sel_i : '0;
  assign w_seen_next   = seen_q | w_accept_mask;
  assign w_publish     = &w_seen_next;
  assign w_fire        = !w_accept && (tmo_cnt_q == TMO_PRE);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_shadow
    assign shadow_code_d[4*k +: 4] = w_accept_mask[k] ? w_code : shadow_code_q[4*k +: 4];
    assign shadow_blank_d[k]       = w_accept_mask[k] ? w_blank : shadow_blank_q[k];
    assign shadow_err_d[k]         = w_accept_mask[k] ? w_err : shadow_err_q[k];
  end

  always_comb begin
    seen_d = (w_publish || w_fire) ? '0 : w_seen_next;
    if (w_accept) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    timeout_d = w_accept ? 1'b0 : (timeout_q | w_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q         <= '0;
      shadow_code_q  <= '0;
      shadow_blank_q <= '0;
      shadow_err_q   <= '0;
      tmo_cnt_q      <= '0;
      timeout_q      <= 1'b0;
      digits_q       <= '0;
      blank_q        <= '0;
      err_q          <= '0;
      frame_valid_q  <= 1'b0;
    end else begin
      seen_q         <= seen_d;
      shadow_code_q  <= shadow_code_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_err_q   <= shadow_err_d;
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_q      <= timeout_d;
      frame_valid_q  <= w_publish;
      if (w_publish) begin
        digits_q <= shadow_code_d;
        blank_q  <= shadow_blank_d;
        err_q    <= shadow_err_d;
      end
    end
  end

  assign digits_o      = digits_q;
  assign blank_o       = blank_q;
  assign err_o         = err_q;
  assign frame_valid_o = frame_valid_q;
  assign timeout_o     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// Module   : tb_seg7_scan_decoder
// Purpose  : Directed self-checking bench for seg7_scan_decoder
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'd0;
  logic [3:0]  sel = 4'd0;
  logic [15:0] digits;
  logic [3:0]  blank, err;
  logic        frame_valid, timeout;

  int n_checks  = 0;
  int n_errors  = 0;
  int pulse_cnt = 0;
  int p0;

  seg7_scan_decoder #(
    .NUM_DIGITS     (4),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_i         (seg),
    .dig_sel_i     (sel),
    .digits_o      (digits),
    .blank_o       (blank),
    .err_o         (err),
    .frame_valid_o (frame_valid),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid) pulse_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic [6:0] p);
    sel = s;
    seg = p;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] s, input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) step(s, p);
  endtask

  task automatic do_reset();
    sel   = 4'd0;
    seg   = 7'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'd0, 7'd0);
  endtask

  initial begin
    #2;
    check_val("rst_digits", digits, 16'h0000);
    check_val("rst_blank", blank, 4'h0);
    check_val("rst_err", err, 4'h0);
    check_val("rst_valid", frame_valid, 1'b0);
    check_val("rst_timeout", timeout, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'd0, 7'd0);

    // Full frame "4321" and pulse latency
    p0 = pulse_cnt;
    hold(4'b0001, 7'b0110000, 6);
    hold(4'b0010, 7'b1101101, 6);
    hold(4'b0100, 7'b1111001, 6);
    hold(4'b1000, 7'b0110011, 3);
    check_val("ff_early", frame_valid, 1'b0);
    step(4'b1000, 7'b0110011);
    check_val("ff_latency", frame_valid, 1'b1);
    check_val("ff_digits", digits, 16'h4321);
    check_val("ff_blank", blank, 4'h0);
    check_val("ff_err", err, 4'h0);
    step(4'b1000, 7'b0110011);
    check_val("ff_pulse_end", frame_valid, 1'b0);
    hold(4'b1000, 7'b0110011, 4);
    check_val("ff_one_pulse", pulse_cnt - p0, 1);

    // Glitch rejection: short-lived patterns are never captured
    do_reset();
    p0 = pulse_cnt;
    hold(4'b0010, 7'b1111110, 3);
    hold(4'b0010, 7'b0110000, 4);
    hold(4'b0000, 7'b0000000, 2);
    check_val("gl_nopulse", pulse_cnt - p0, 0);
    hold(4'b0001, 7'b1111111, 6);
    hold(4'b0100, 7'b1011011, 6);
    hold(4'b1000, 7'b1110011, 6);
    check_val("gl_pulse", pulse_cnt - p0, 1);
    check_val("gl_digits", digits, 16'h9518);
    hold(4'b0001, 7'b1111111, 6);
    hold(4'b0100, 7'b1011011, 6);
    hold(4'b1000, 7'b1110011, 6);
    hold(4'b0010, 7'b1011111, 3);
    hold(4'b0000, 7'b0000000, 3);
    check_val("gl_nopulse2", pulse_cnt - p0, 1);
    check_val("gl_hold", digits, 16'h9518);

    // Blank and illegal glyph flags
    do_reset();
    p0 = pulse_cnt;
    hold(4'b0001, 7'b1101101, 6);
    hold(4'b0010, 7'b1111001, 6);
    hold(4'b0100, 7'b0000000, 6);
    hold(4'b1000, 7'b1000000, 6);
    check_val("fl_pulse", pulse_cnt - p0, 1);
    check_val("fl_digits", digits, 16'hEF32);
    check_val("fl_blank", blank, 4'b0100);
    check_val("fl_err", err, 4'b1000);

    // Reset mid-frame with published outputs non-zero
    hold(4'b0001, 7'b0110011, 6);
    hold(4'b0010, 7'b1011011, 6);
    hold(4'b0100, 7'b1011111, 6);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mr_digits", digits, 16'h0000);
    check_val("mr_blank", blank, 4'h0);
    check_val("mr_err", err, 4'h0);
    check_val("mr_timeout", timeout, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pulse_cnt;
    hold(4'b1000, 7'b1111111, 6);
    hold(4'b0000, 7'b0000000, 3);
    check_val("mr_nopulse", pulse_cnt - p0, 0);

    // Illegal selects accept nothing and leave the partial frame alone
    do_reset();
    p0 = pulse_cnt;
    hold(4'b0001, 7'b1110000, 6);
    hold(4'b0011, 7'b1011011, 20);
    check_val("il_multi", pulse_cnt - p0, 0);
    hold(4'b0010, 7'b0110011, 6);
    hold(4'b0100, 7'b1011111, 6);
    hold(4'b1000, 7'b1111110, 6);
    check_val("il_pulse", pulse_cnt - p0, 1);
    check_val("il_digits", digits, 16'h0647);
    p0 = pulse_cnt;
    hold(4'b0000, 7'b1111111, 20);
    check_val("il_zero", pulse_cnt - p0, 0);
    check_val("il_zero_tmo", timeout, 1'b0);

    // Timeout drops the partial frame
    do_reset();
    p0 = pulse_cnt;
    hold(4'b0001, 7'b0110000, 6);
    hold(4'b0010, 7'b1101101, 4);
    hold(4'b0000, 7'b0000000, 31);
    check_val("to_before", timeout, 1'b0);
    step(4'b0000, 7'b0000000);
    check_val("to_set", timeout, 1'b1);
    hold(4'b0100, 7'b1111001, 3);
    check_val("to_sticky", timeout, 1'b1);
    step(4'b0100, 7'b1111001);
    check_val("to_clear", timeout, 1'b0);
    hold(4'b0100, 7'b1111001, 2);
    hold(4'b1000, 7'b0110011, 6);
    check_val("to_nopulse", pulse_cnt - p0, 0);
    hold(4'b0001, 7'b0110000, 6);
    hold(4'b0010, 7'b1101101, 6);
    check_val("to_pulse", pulse_cnt - p0, 1);
    check_val("to_digits", digits, 16'h4321);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side decoder for a multiplexed 7-segment display bus; the inverse of the team's BCD-to-segment encoder.
- Watches the segment lines and the one-hot digit-select lines and filters out scan glitches.
- Turns each stable segment pattern back into a 4-bit code per digit.
- Publishes a complete, coherent frame of all digits with a one-cycle valid pulse.
- Used to check display drivers in-system and to read external panel controllers.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4: consecutive identical cycles needed before a sample is accepted (1..255).
- TIMEOUT_CYCLES, 65535: cycles without any accepted sample before the partial frame is discarded (at least 2).

Ports:
- clk  in  1  Single clock; all logic on its rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- seg_i  in  7  Segment lines, active-high; bit6=a, bit5=b, ... bit0=g. Synchronous to clk; any synchronisation is done upstream.
- dig_sel_i  in  NUM_DIGITS  Digit select, one-hot, active-high.
- digits_o  out  4*NUM_DIGITS  Decoded frame; digit k is at [4k+3:4k].
- blank_o  out  NUM_DIGITS  Per-digit flag: pattern was all-off.
- err_o  out  NUM_DIGITS  Per-digit flag: pattern is not a legal glyph.
- frame_valid_o  out  1  One-cycle pulse; digits_o, blank_o and err_o are updated in the same cycle.
- timeout_o  out  1  Sticky level; cleared by the next accepted sample.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - Seen-mask and shadow registers are cleared.
  - FSM enters WAIT.
  - Hold and timeout counters are 0.
  - Assertion mid-frame discards the partial frame.
- Input pair P = {dig_sel_i, seg_i}. Previous P is registered every cycle.
- FSM states:
  - WAIT: dig_sel_i is not exactly one-hot (zero or multi-hot). Hold count is 0. Moves to HOLD (count=1) on the first cycle dig_sel_i is one-hot.
  - HOLD: P equals the previous P, so count increments. If P changes while still one-hot, count returns to 1 and the FSM stays in HOLD. If P becomes not one-hot, the FSM goes to WAIT. When count reaches STABLE_CYCLES, the sample is accepted and the FSM goes to DONE.
  - DONE: no re-capture while P is unchanged. A P change goes to HOLD (count=1), or to WAIT if not one-hot.
  - STABLE_CYCLES=1: a one-hot P is accepted in its first cycle.
- Accept actions, for selected digit k:
  - Decode seg_i into shadow[k] and set seen[k].
  - A repeat capture of the same digit before the frame completes overwrites shadow[k] (latest wins).
- Decode table: inverse of the encoder's patterns.
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1110011
  - 0000000: code 4'hF, blank set.
  - Any other pattern: code 4'hE, err set.
- Frame completion:
  - On the cycle after seen becomes all-ones, shadow and flags are copied to the outputs, frame_valid_o pulses, and seen clears.
  - An accept in that same cycle is recorded into the new frame.
  - Latency: frame_valid_o is high in the cycle after the final digit's STABLE_CYCLES-th stable cycle.
  - Outputs hold their values between frames.
- Timeout:
  - Counter increments every cycle and clears on accept. It saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: timeout_o goes to 1 and seen clears (partial frame dropped). Published outputs are unchanged.
  - The next accept clears timeout_o.

Decomposition:
- Package seg7_pkg holds:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - CODE_BLANK = 4'hF and CODE_ERR = 4'hE.
  - The FSM state enum {WAIT, HOLD, DONE}.
  - The encoder is also to import the segment constants from seg7_pkg.
- Sub-module seg7_pattern_decode: combinational; seg[6:0] in, code[3:0], blank and err out.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4):
- Full frame: select 0001/0010/0100/1000 with patterns 0110000/1101101/1111001/0110011, each held 6 cycles -> exactly one frame_valid_o pulse, one cycle after the 4th stable cycle of digit 3; digits_o=16'h4321; blank_o=0, err_o=0.
- Glitch: digit 1 shows 1111110 for 3 cycles, then changes to 0110000 for 4 cycles -> only code 1 captured; no pulse until the other digits are captured.
- Flags: digit 2 shows 0000000 and digit 3 shows 1000000 in a full frame -> nibble2=F with blank_o[2]=1; nibble3=E with err_o[3]=1.
- Illegal select: dig_sel_i=0011 or 0000 held 20 cycles with a valid pattern -> no accepts; seen unchanged; no pulse.
- Timeout (TIMEOUT_CYCLES=32): capture digits 0 and 1, then idle -> timeout_o=1 exactly 32 cycles after the last accept. Resuming with digits 2 and 3 only produces no pulse; all 4 digits are needed, and the first accept clears timeout_o.
- Reset: assert rst_n low mid-clock after 3 digits captured -> all outputs 0 immediately. After release, a 1-digit stimulus produces no pulse.
